// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: replays ps2_key toggle-strobe events as PS/2 device-to-host frames
module ps2_key_serializer #(
    parameter int HALF_PERIOD = 550,
    parameter int GAP = 1100,
    parameter int FIFO_AW = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP} state_t;
    state_t state, state_n;
    logic [9:0] fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic old_toggle, push, pop, full, empty, accept;
    logic [9:0] head;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] bit_idx, bit_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [2:0] pend, pend_n;
    logic [7:0] code_q, code_n, byte_n;
    logic [10:0] frame_n;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr - rd_ptr) == (FIFO_AW + 1)'(DEPTH);
    assign head = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign push = ps2_key[10] != old_toggle;
    assign pop = state == S_IDLE && !empty && ps2_clk_in;
    assign accept = push && (!full || pop);
    assign busy = state != S_IDLE || !empty;
    // pend flags the bytes still owed for the current event: {E0, F0, code}
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        bit_n = bit_idx;
        gap_n = gap_cnt;
        pend_n = pend;
        code_n = code_q;
        case (state)
            S_IDLE: if (pop) begin
                state_n = S_LOAD;
                code_n = head[7:0];
                pend_n = {head[8], !head[9], 1'b1};
            end
            S_LOAD: begin
                state_n = S_FRAME;
                cnt_n = '0;
                bit_n = '0;
            end
            S_FRAME: if (cnt == CW'(HALF_PERIOD - 1) && bit_idx != 4'd10 && !ps2_clk_in) begin
                state_n = S_GAP;
                gap_n = '0;
            end else if (cnt == CW'(2 * HALF_PERIOD - 1)) begin
                cnt_n = '0;
                if (bit_idx == 4'd10) begin
                    state_n = S_GAP;
                    gap_n = '0;
                    pend_n = pend[2] ? {1'b0, pend[1:0]} : pend[1] ? {2'b00, pend[0]} : 3'b000;
                end else
                    bit_n = bit_idx + 4'd1;
            end else
                cnt_n = cnt + CW'(1);
            S_GAP: if (ps2_clk_in) begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_n = |pend ? S_FRAME : S_IDLE;
                    cnt_n = '0;
                    bit_n = '0;
                end else
                    gap_n = gap_cnt + GW'(1);
            end
            default: state_n = S_IDLE;
        endcase
        byte_n = pend_n[2] ? 8'hE0 : pend_n[1] ? 8'hF0 : code_n;
        frame_n = {1'b1, ~^byte_n, byte_n, 1'b0};
    end
    // Line outputs are registered from next-state so the PS/2 pins never glitch
    always_ff @(posedge clk_sys) begin
        old_toggle <= ps2_key[10];
        if (!reset_n) begin
            state <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            pend <= '0;
            code_q <= '0;
            overflow <= 1'b0;
            ps2_clk_out <= 1'b1;
            ps2_data_out <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            gap_cnt <= gap_n;
            pend <= pend_n;
            code_q <= code_n;
            overflow <= push && !accept;
            if (accept)
                wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
            ps2_clk_out <= !(state_n == S_FRAME && cnt_n >= CW'(HALF_PERIOD));
            ps2_data_out <= state_n != S_FRAME || frame_n[bit_n];
        end
    end
    always_ff @(posedge clk_sys)
        if (reset_n && accept)
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= ps2_key[9:0];
endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb_ps2_key_serializer: directed bench for the PS/2 key serializer (HALF_PERIOD=4, GAP=8)
module tb_ps2_key_serializer;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic [10:0] ps2_key;
    logic ps2_clk_in;
    logic ps2_clk_out, ps2_data_out, busy, overflow;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    ps2_key_serializer #(.HALF_PERIOD(4), .GAP(8), .FIFO_AW(2)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_key(ps2_key),
        .ps2_clk_in(ps2_clk_in),
        .ps2_clk_out(ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_start(output int t0);
        int g = 0;
        while (ps2_data_out !== 1'b0 && g < 3000) begin
            tick;
            g++;
        end
        check("start_bit", 32'(ps2_data_out), 0);
        t0 = cyc;
    endtask

    // Captures one frame on ps2_clk_out falling edges; returns at the first cycle after the frame
    task automatic rx_frame(input string tag, input logic [10:0] exp, output int t0);
        logic [10:0] bits = '0;
        logic p;
        int g;
        wait_start(t0);
        for (int b = 0; b < 11; b++) begin
            g = 0;
            do begin
                p = ps2_clk_out;
                tick;
                g++;
            end while (!(p && !ps2_clk_out) && g < 100);
            bits[b] = ps2_data_out;
        end
        g = 0;
        while (!ps2_clk_out && g < 100) begin
            tick;
            g++;
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp));
        check({tag, "_len"}, cyc - t0, 88);
    endtask

    task automatic quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            tick;
            if (ps2_data_out !== 1'b1 || ps2_clk_out !== 1'b1)
                bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        logic [10:0] fr4 [4] = '{11'h42C, 11'h63C, 11'h44C, 11'h44A};
        int ta, tb, tc, s, ovc, bad;
        ps2_key = '0;
        ps2_clk_in = 1'b1;
        reset_n = 1'b0;
        // 1: reset with the strobe toggling every cycle
        for (int i = 0; i < 10; i++) begin
            ps2_key[10] = ~ps2_key[10];
            tick;
        end
        check("rst_clk", 32'(ps2_clk_out), 1);
        check("rst_data", 32'(ps2_data_out), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        quiet("rst_quiet", 150);
        check("rst_busy_after", 32'(busy), 0);
        // 2: press 0x29
        send_event(1'b1, 1'b0, 8'h29);
        rx_frame("k29", 11'h452, ta);
        check("k29_busy_gap", 32'(busy), 1);
        repeat (8) tick;
        check("k29_busy_end", 32'(busy), 0);
        // 3: release of extended 0x75
        send_event(1'b0, 1'b1, 8'h75);
        rx_frame("e0", 11'h5C0, ta);
        rx_frame("f0", 11'h7E0, tb);
        rx_frame("k75", 11'h4EA, tc);
        check("gap_e0_f0", tb - ta, 96);
        check("gap_f0_75", tc - tb, 96);
        repeat (8) tick;
        check("k75_busy_end", 32'(busy), 0);
        // 4: five events back to back with the host inhibiting, depth 4
        ps2_clk_in = 1'b0;
        ovc = 0;
        for (int i = 0; i < 5; i++) begin
            send_event(1'b1, 1'b0, codes[i]);
            tick;
            ovc += int'(overflow);
            if (i == 3)
                check("ovf_4th", 32'(overflow), 0);
            if (i == 4)
                check("ovf_5th", 32'(overflow), 1);
        end
        tick;
        ovc += int'(overflow);
        check("ovf_count", ovc, 1);
        check("ovf_busy", 32'(busy), 1);
        check("ovf_data_idle", 32'(ps2_data_out), 1);
        ps2_clk_in = 1'b1;
        for (int i = 0; i < 4; i++)
            rx_frame($sformatf("q%0d", i), fr4[i], ta);
        quiet("q_no_5th", 150);
        check("q_busy_end", 32'(busy), 0);
        // 5: host inhibit during the high phase of bit 3
        send_event(1'b1, 1'b0, 8'h1C);
        wait_start(s);
        repeat (25) tick;
        ps2_clk_in = 1'b0;
        repeat (3) tick;
        check("inh_clk", 32'(ps2_clk_out), 1);
        check("inh_data", 32'(ps2_data_out), 1);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (ps2_data_out !== 1'b1 || ps2_clk_out !== 1'b1)
                bad++;
            if (i == 17)
                ps2_clk_in = 1'b1;
            tick;
        end
        check("inh_quiet", bad, 0);
        rx_frame("k1C", 11'h438, ta);
        check("inh_resend_at", ta - s, 53);
        repeat (8) tick;
        check("inh_busy_end", 32'(busy), 0);
        // 6: reset in the middle of the second byte of E0 F0 75
        send_event(1'b0, 1'b1, 8'h75);
        rx_frame("r_e0", 11'h5C0, ta);
        wait_start(tb);
        repeat (20) tick;
        reset_n = 1'b0;
        tick;
        check("mid_rst_clk", 32'(ps2_clk_out), 1);
        check("mid_rst_data", 32'(ps2_data_out), 1);
        check("mid_rst_busy", 32'(busy), 0);
        repeat (3) tick;
        reset_n = 1'b1;
        quiet("mid_rst_quiet", 200);
        check("mid_rst_busy_end", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
